// File: rtl/ysyx_22040127_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_mem_arbiter_if
// Bundles the three handshakes around the shared memory port:
//   ifu_*  : instruction-fetch requester (read only)
//   lsu_*  : load/store requester (read or masked write)
//   mem_*  : single downstream port towards the pmem model
// Modports:
//   slave  : the arbiter's view. It is the target of the IFU/LSU requests and
//            drives the downstream memory request.
//   master : the surrounding core + memory view (requesters and pmem model).
// ---------------------------------------------------------------------------
interface ysyx_22040127_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_22040127_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_mem_arbiter
// Shares one memory port between the IFU and the LSU with a single
// transaction in flight. In IDLE a requester is granted combinationally,
// its request is latched on accept, presented downstream in REQ until
// mem_req_ready, and the response is steered back to the owner in WAIT.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : ysyx_22040127_mem_arbiter_if.slave (IFU, LSU and memory handshakes)
// Build option:
//   YSYX_22040127_ARB_RR_EN defined   -> round-robin between IFU and LSU
//   YSYX_22040127_ARB_RR_EN undefined -> fixed priority, LSU over IFU
// ---------------------------------------------------------------------------
module ysyx_22040127_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22040127_mem_arbiter_if.slave    bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_lsu_q, owner_lsu_d;   // 0 = IFU, 1 = LSU
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              grant_lsu;
`ifdef YSYX_22040127_ARB_RR_EN
  logic              last_lsu_q, last_lsu_d;     // 0 = IFU won last accept
`endif

  // Grant decision; grant_lsu implies lsu_req_valid.
  always_comb begin
    grant_lsu = bus.lsu_req_valid;
`ifdef YSYX_22040127_ARB_RR_EN
    if (bus.lsu_req_valid && bus.ifu_req_valid) grant_lsu = ~last_lsu_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
`ifdef YSYX_22040127_ARB_RR_EN
    last_lsu_d  = last_lsu_q;
`endif
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.ifu_rdata      = owner_lsu_q ? '0 : bus.mem_rdata;
    bus.lsu_rdata      = owner_lsu_q ? bus.mem_rdata : '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_addr       = addr_q;
    bus.mem_wen        = wen_q;
    bus.mem_wdata      = wdata_q;
    bus.mem_wmask      = wmask_q;

    unique case (state_q)
      IDLE: begin
        bus.lsu_req_ready = grant_lsu;
        bus.ifu_req_ready = bus.ifu_req_valid & ~grant_lsu;
        if (grant_lsu) begin
          owner_lsu_d = 1'b1;
          addr_d      = bus.lsu_addr;
          wen_d       = bus.lsu_wen;
          wdata_d     = bus.lsu_wdata;
          wmask_d     = bus.lsu_wmask;
          state_d     = REQ;
`ifdef YSYX_22040127_ARB_RR_EN
          last_lsu_d  = 1'b1;
`endif
        end else if (bus.ifu_req_valid) begin
          // Fetches are plain reads: no write enable, no byte mask.
          owner_lsu_d = 1'b0;
          addr_d      = bus.ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
          state_d     = REQ;
`ifdef YSYX_22040127_ARB_RR_EN
          last_lsu_d  = 1'b0;
`endif
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          bus.ifu_resp_valid = ~owner_lsu_q;
          bus.lsu_resp_valid = owner_lsu_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response arriving while reset is asserted belongs to an abandoned
    // transaction and must not leak to either requester.
    if (rst) begin
      bus.ifu_req_ready  = 1'b0;
      bus.lsu_req_ready  = 1'b0;
      bus.ifu_resp_valid = 1'b0;
      bus.lsu_resp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
`ifdef YSYX_22040127_ARB_RR_EN
      last_lsu_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
`ifdef YSYX_22040127_ARB_RR_EN
      last_lsu_q  <= last_lsu_d;
`endif
    end
  end
endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040127_mem_arbiter
// Directed and randomized transactions against a transaction-level model of
// the arbiter: who should win, what the memory port should show, and which
// requester should see the response.
// ---------------------------------------------------------------------------
module tb_ysyx_22040127_mem_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
`ifdef YSYX_22040127_ARB_RR_EN
  bit   m_last_lsu;
`endif

  ysyx_22040127_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22040127_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_grant_lsu(input bit iv, input bit lv);
`ifdef YSYX_22040127_ARB_RR_EN
    if (iv && lv) return !m_last_lsu;
`endif
    return lv;
  endfunction

  task automatic model_reset();
`ifdef YSYX_22040127_ARB_RR_EN
    m_last_lsu = 1'b0;
`endif
  endtask

  task automatic model_accept(input bit g);
`ifdef YSYX_22040127_ARB_RR_EN
    m_last_lsu = g;
`else
    if (g) begin end
`endif
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic txn(input bit iv, input bit lv, input logic [63:0] ia,
                     input logic [63:0] la, input bit lw, input logic [63:0] lwd,
                     input logic [7:0] lwm, input int req_dly, input int resp_dly,
                     input logic [63:0] rd, input bit spur);
    bit g;
    logic [63:0] e_addr, e_wd;
    logic e_wen;
    logic [7:0] e_wm;
    bus.ifu_req_valid = iv;  bus.ifu_addr = ia;
    bus.lsu_req_valid = lv;  bus.lsu_addr = la;
    bus.lsu_wen = lw; bus.lsu_wdata = lwd; bus.lsu_wmask = lwm;
    #1;
    g = exp_grant_lsu(iv, lv);
    chk("idle_ifu_ready", bus.ifu_req_ready, iv && !g);
    chk("idle_lsu_ready", bus.lsu_req_ready, g);
    if (!iv && !lv) begin
      @(posedge clk); #1;
      chk("no_req_mem_valid", bus.mem_req_valid, 0);
      return;
    end
    e_addr = g ? la : ia;
    e_wen  = g ? lw : 1'b0;
    e_wd   = g ? lwd : 64'd0;
    e_wm   = g ? lwm : 8'd0;
    model_accept(g);
    @(posedge clk); #1;
    // Requests are committed: scramble the requester side.
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    bus.ifu_addr = {$urandom, $urandom}; bus.lsu_addr = {$urandom, $urandom};
    bus.lsu_wdata = {$urandom, $urandom}; bus.lsu_wmask = 8'($urandom);
    bus.lsu_wen = 1'($urandom);
    for (int i = 0; i < req_dly; i++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = spur; bus.mem_rdata = {$urandom, $urandom};
      bus.ifu_req_valid = 1'($urandom); bus.lsu_req_valid = 1'($urandom);
      #1;
      chk("req_hold_valid", bus.mem_req_valid, 1);
      chk("req_hold_addr", bus.mem_addr, e_addr);
      chk("req_hold_wdata", bus.mem_wdata, e_wd);
      chk("req_hold_wmask", bus.mem_wmask, e_wm);
      chk("req_hold_wen", bus.mem_wen, e_wen);
      chk("req_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
      chk("req_no_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      @(posedge clk); #1;
    end
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0;
    #1;
    chk("req_valid", bus.mem_req_valid, 1);
    chk("req_addr", bus.mem_addr, e_addr);
    chk("req_wen", bus.mem_wen, e_wen);
    chk("req_wdata", bus.mem_wdata, e_wd);
    chk("req_wmask", bus.mem_wmask, e_wm);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < resp_dly; i++) begin
      bus.ifu_req_valid = 1'($urandom); bus.lsu_req_valid = 1'($urandom);
      #1;
      chk("wait_req_low", bus.mem_req_valid, 0);
      chk("wait_no_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      chk("wait_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
      @(posedge clk); #1;
    end
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = rd;
    #1;
    chk("resp_ifu_valid", bus.ifu_resp_valid, !g);
    chk("resp_lsu_valid", bus.lsu_resp_valid, g);
    chk("resp_rdata", g ? bus.lsu_rdata : bus.ifu_rdata, rd);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("post_resp_quiet", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}, 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    model_reset();
    rst = 1'b1;
    bus.ifu_req_valid = 0; bus.ifu_addr = 0;
    bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0;
    bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    chk("rst_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // IFU fetch with immediate memory handshake.
    txn(1, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h0000_0013_0000_0093, 0);
    // LSU store stalled three cycles downstream.
    txn(0, 1, 0, 64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F, 3, 1, 64'h0, 0);
    // Contention rounds, then IFU alone.
    for (int r = 0; r < 3; r++)
      txn(1, 1, 64'h8000_0100 + 64'(r * 4), 64'h8000_2000 + 64'(r * 8), 0, 0, 0,
          0, 0, 64'h1111_0000 + 64'(r), 0);
    txn(1, 0, 64'h8000_0200, 0, 0, 0, 0, 1, 0, 64'h2222, 0);

    // Spurious response while idle.
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 64'h1234;
    #1;
    chk("spur_idle_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    @(posedge clk); #1;
    chk("spur_idle_mem_valid", bus.mem_req_valid, 0);
    chk("spur_idle_resp2", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    bus.mem_resp_valid = 1'b0;
    txn(0, 1, 0, 64'h8000_3000, 0, 0, 0, 0, 0, 64'h3333, 0);

    // Reset while waiting for the response.
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 64'h8000_4000;
    model_accept(exp_grant_lsu(1, 0));
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    rst = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 64'h5555;
    #1;
    chk("rst_wait_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    #1;
    chk("rst_wait_mem_valid", bus.mem_req_valid, 0);
    chk("rst_wait_resp2", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    #1;
    chk("rst_idle_lsu_ready", bus.lsu_req_ready, exp_grant_lsu(1, 1));
    chk("rst_idle_ifu_ready", bus.ifu_req_ready, !exp_grant_lsu(1, 1));
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("rst_still_idle", bus.mem_req_valid, 0);

    // Randomized traffic.
    for (int k = 0; k < 25; k++) begin
      txn(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          1'($urandom), {$urandom, $urandom}, 8'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          {$urandom, $urandom}, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040127_mem_arbiter.md
Name: ysyx_22040127_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- The downstream port feeds the DPI-backed pmem model.
- One transaction is in flight at a time.
- Arbitrates, latches the winning request, drives the memory handshake, and routes the response back to the owner.
- Sits between the core's fetch/LSU logic and the memory module; it replaces the separate fetch and data memory paths.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; write mask width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ifu_req_valid  in  1  IFU request
ifu_req_ready  out  1  IFU request accepted this cycle when valid&ready
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse)
ifu_rdata  out  DATA_W  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted when valid&ready
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1=store, 0=load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  store byte enables
lsu_resp_valid  out  1  LSU completion pulse (load data or store ack)
lsu_rdata  out  DATA_W  load data
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_W  latched store data
mem_wmask  out  DATA_W/8  latched mask
mem_resp_valid  in  1  downstream response
mem_rdata  in  DATA_W  downstream read data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- Outputs at reset: all *_ready, *_resp_valid and mem_req_valid are 0; mem_addr/mem_wdata/mem_wmask/mem_wen are 0; owner = IFU.
- IDLE, grant: grant is combinational. Fixed priority: LSU over IFU. Only the granted requester sees ready=1; the other sees 0. Both readies are 0 outside IDLE.
- IDLE, accept: on accept, latch addr/wen/wdata/wmask and owner, then go to REQ. IFU requests latch wen=0 and wmask=0.
- REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready. When mem_req_ready=1, go to WAIT.
- WAIT: when mem_resp_valid=1, route it to the owner. owner_resp_valid=mem_resp_valid and owner_rdata=mem_rdata, combinational, same cycle. Then go to IDLE.
- Non-owner resp_valid is always 0. The non-owner's rdata is don't-care, but the implementation drives 0.
- Latency: accept at cycle N; mem_req_valid at N+1. With mem_req_ready and mem_resp_valid both 1 immediately, resp arrives at N+2. Next accept earliest at N+3.
- mem_resp_valid in IDLE or REQ is ignored, with no state change.
- Requester dropping valid while not accepted has no effect. Once accepted, the request is committed; the requester cannot cancel it.
- rst mid-transaction: return to IDLE and deassert mem_req_valid the next cycle. The pending response is discarded and never forwarded.
- Stores complete only on mem_resp_valid (ack); wdata and wmask are passed unchanged.

Optional Feature:
- Macro: YSYX_22040127_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register updates on each accept. When both requesters are valid, the one not granted last wins. Reset value last_grant=IFU, so LSU wins the first tie. A single requester is always granted.
- Undefined: fixed LSU-over-IFU priority; no last_grant register.

Test Plan:
- IFU only: ifu_addr=0x80000000, memory returns 0x0000001300000093 with mem_req_ready=1 and 1-cycle response. Required: mem_req_valid at N+1 with mem_addr=0x80000000; ifu_resp_valid pulse at N+2 with ifu_rdata=0x0000001300000093; lsu_resp_valid stays 0.
- LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held 0 for 3 cycles. Required: mem_req_valid and the latched fields are stable for those 3 cycles; one lsu_resp_valid pulse follows the ack.
- Simultaneous IFU+LSU, macro off, for 3 rounds. Required: LSU is granted every round; IFU is granted only when lsu_req_valid=0.
- Simultaneous IFU+LSU, macro on. Required: grants alternate LSU, IFU, LSU, IFU.
- rst asserted in WAIT, then mem_resp_valid. Required: no resp_valid on either requester; state is IDLE; both readies behave as IDLE after rst drops.
- Spurious mem_resp_valid in IDLE with rdata=0x1234. Required: no resp pulse and no state change.
